// File: rtl/btn_debounce.sv
// btn_debounce: debounces a bank of raw push buttons against a 1 ms tick derived
// from the board timer's square wave, and emits one-cycle press/release pulses.
// Build option: define BTN_REPEAT_EN to add per-button auto-repeat on btn_press.
module btn_debounce #(
    parameter int unsigned N               = 4,
    parameter int unsigned DB_MS           = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_1ms,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_out,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release
);

    localparam int unsigned   CW      = 10;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_MS - 1);
`ifdef BTN_REPEAT_EN
    localparam logic [CW-1:0] RPT_LAST   = CW'(REPEAT_DELAY_MS - 1);
    localparam logic [CW-1:0] RPT_RELOAD = CW'(REPEAT_DELAY_MS - REPEAT_RATE_MS);
`endif

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_t;

    logic [1:0]   ms_sync;
    logic         ms_prev;
    logic         tick;
    logic [N-1:0] btn_meta;
    logic [N-1:0] btn_s;

    // Synchronise the 1 ms wave and register a one-cycle tick on its rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_sync <= '0;
            ms_prev <= 1'b0;
            tick    <= 1'b0;
        end else begin
            ms_sync <= {ms_sync[0], clk_1ms};
            ms_prev <= ms_sync[1];
            tick    <= ms_sync[1] & ~ms_prev;
        end
    end

    // Two-flop synchroniser per raw button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= '0;
            btn_s    <= '0;
        end else begin
            btn_meta <= btn_in;
            btn_s    <= btn_meta;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_btn
        state_t        state;
        logic [CW-1:0] cnt;
        logic          out_q;
        logic          press_q;
        logic          rel_q;
        logic          flip_c;
        logic          rpt_c;

        // Debounced level inverts on the tick that completes DB_MS stable mismatched ticks.
        assign flip_c = (state == ST_COUNT) && (btn_s[i] != out_q) && tick && (cnt == DB_LAST);

`ifdef BTN_REPEAT_EN
        logic [CW-1:0] rcnt;

        // A level change on the same tick takes priority over a repeat event.
        assign rpt_c = out_q && !flip_c && tick && (rcnt == RPT_LAST);

        // Hold-time counter: cleared while released or on the press, reloaded after each repeat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt <= '0;
            end else if (!out_q || flip_c) begin
                rcnt <= '0;
            end else if (rpt_c) begin
                rcnt <= RPT_RELOAD;
            end else if (tick) begin
                rcnt <= rcnt + CW'(1);
            end
        end
`else
        assign rpt_c = 1'b0;
`endif

        // Per-button debounce FSM with registered level and edge pulses.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= ST_STABLE;
                cnt     <= '0;
                out_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= (flip_c && !out_q) || rpt_c;
                rel_q   <= flip_c && out_q;
                case (state)
                    ST_STABLE: begin
                        cnt <= '0;
                        if (btn_s[i] != out_q) begin
                            state <= ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        if (btn_s[i] == out_q) begin
                            // Any return to the current level abandons the count, tick or not.
                            cnt   <= '0;
                            state <= ST_STABLE;
                        end else if (tick) begin
                            if (cnt == DB_LAST) begin
                                out_q <= ~out_q;
                                cnt   <= '0;
                                state <= ST_STABLE;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end
                endcase
            end
        end

        assign btn_out[i]     = out_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = rel_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed stimulus with a scoreboard of expected press/release
// events; a monitor pops and compares whenever the DUT emits a pulse.
module tb_btn_debounce;

    localparam int unsigned N               = 4;
    localparam int unsigned DB_MS           = 20;
    localparam int unsigned REPEAT_DELAY_MS = 50;
    localparam int unsigned REPEAT_RATE_MS  = 10;

    logic         clk;
    logic         rst_n;
    logic         clk_1ms;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_out;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    typedef struct {
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] out;
        int           ms;
        int           id;
    } exp_t;

    exp_t         exp_q[$];
    int           checks  = 0;
    int           errors  = 0;
    int           ms_no   = 0;
    int           n_exp   = 0;
    logic [N-1:0] exp_out = '0;

    btn_debounce #(
        .N              (N),
        .DB_MS          (DB_MS),
        .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
        .REPEAT_RATE_MS (REPEAT_RATE_MS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_1ms    (clk_1ms),
        .btn_in     (btn_in),
        .btn_out    (btn_out),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // 10-unit clk; clk_1ms has a 20-clk period, rising at 102, 302, ... (3 units before a clk rise).
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clk_1ms = 1'b0;
        #2;
        forever #100 clk_1ms = ~clk_1ms;
    end

    // Bench-side millisecond index, one per clk_1ms rising edge.
    always @(posedge clk_1ms) ms_no = ms_no + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached with %0d events outstanding, want end of test", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // An input applied 1 unit after clk_1ms rise m is first counted by the tick of rise m,
    // so the 20th qualifying tick (the one the output flips on) is rise m+19.
    task automatic push_exp(input logic [N-1:0] p, input logic [N-1:0] r, input int at_ms);
        exp_t e;
        exp_out = (exp_out | p) & ~r;
        e.press = p;
        e.rel   = r;
        e.out   = exp_out;
        e.ms    = at_ms;
        e.id    = n_exp;
        n_exp++;
        exp_q.push_back(e);
    endtask

    task automatic at_tick();
        @(posedge clk_1ms);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) at_tick();
    endtask

    task automatic drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d expected events outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every pulse cycle must match the next expected event, at the expected ms.
    always @(negedge clk) begin : monitor
        exp_t e;
        if ((btn_press | btn_release) != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got press %h release %h out %h at ms %0d, want no event",
                         btn_press, btn_release, btn_out, ms_no);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("ev%0d_press", e.id), btn_press, e.press);
                check($sformatf("ev%0d_release", e.id), btn_release, e.rel);
                check($sformatf("ev%0d_out", e.id), btn_out, e.out);
                checks++;
                if (ms_no != e.ms) begin
                    errors++;
                    $display("FAIL ev%0d_time: got ms %0d want ms %0d", e.id, ms_no, e.ms);
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        btn_in = 4'hF;

        // Reset held with all buttons pressed: outputs stay quiet.
        for (int k = 0; k < 10; k++) begin
            repeat (10) @(negedge clk);
            check("reset_out", btn_out, 4'h0);
            check("reset_press", btn_press, 4'h0);
            check("reset_release", btn_release, 4'h0);
        end

        // Release reset on a tick boundary: all four debounce together.
        at_tick();
        rst_n = 1'b1;
        push_exp(4'hF, 4'h0, ms_no + 19);
        wait_ticks(20);

        // Release button 2 alone, then the rest one tick later.
        btn_in[2] = 1'b0;
        push_exp(4'h0, 4'h4, ms_no + 19);
        wait_ticks(1);
        btn_in = 4'h0;
        push_exp(4'h0, 4'hB, ms_no + 19);
        wait_ticks(25);
        drain("release_phase");

        // Clean press of button 0, held 25 ticks, then released.
        at_tick();
        btn_in[0] = 1'b1;
        push_exp(4'h1, 4'h0, ms_no + 19);
        wait_ticks(25);
        btn_in[0] = 1'b0;
        push_exp(4'h0, 4'h1, ms_no + 19);
        wait_ticks(25);
        drain("clean_press");

        // Button 1 bounces every 3 ticks, settling high after the last toggle.
        at_tick();
        for (int k = 0; k < 5; k++) begin
            btn_in[1] = ((k % 2) == 0);
            if (k < 4) wait_ticks(3);
        end
        push_exp(4'h2, 4'h0, ms_no + 19);
        wait_ticks(20);
        btn_in[1] = 1'b0;
        push_exp(4'h0, 4'h2, ms_no + 19);
        wait_ticks(25);
        drain("bounce");

        // Button 3 counts for 10 ticks, then a short reset discards the progress.
        // The synchroniser restarts from 0 while clk_1ms is high, so the first tick
        // after reset comes from the current ms; the flip lands 19 ms after it.
        at_tick();
        btn_in[3] = 1'b1;
        wait_ticks(10);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midreset_out", btn_out, 4'h0);
        rst_n = 1'b1;
        push_exp(4'h8, 4'h0, ms_no + 19);
        wait_ticks(25);
        btn_in[3] = 1'b0;
        push_exp(4'h0, 4'h8, ms_no + 19);
        wait_ticks(25);
        drain("reset_mid_count");

        // Long hold of button 0: press at +19, repeats 50 ticks after the press and
        // every 10 after; input drops at +85 so the level falls at +104 before a sixth pulse.
        at_tick();
        begin
            int m;
            m = ms_no;
            btn_in[0] = 1'b1;
            push_exp(4'h1, 4'h0, m + 19);
`ifdef BTN_REPEAT_EN
            for (int k = 0; k < 4; k++) begin
                push_exp(4'h1, 4'h0, m + 69 + 10 * k);
            end
`endif
            wait_ticks(85);
            btn_in[0] = 1'b0;
            push_exp(4'h0, 4'h1, m + 104);
        end
        wait_ticks(25);
        drain("repeat_hold");

        check("final_out", btn_out, 4'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
